csa_job_scheduler: RTL and testbench

CSA_JOB_SCHEDULER -- requirements
Module: csa_job_scheduler

---
 rtl/csa_job_scheduler_if.sv | 24 ++
 rtl/csa_job_scheduler.sv | 125 ++++++++++++
 tb/tb_csa_job_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_job_scheduler_if.sv
// Source-FIFO and calc-instance dispatch signals of the job scheduler.
// The master side is the scheduler; the slave side is the FIFO/instance fabric.
interface csa_job_scheduler_if #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int J = 5
);
  logic           src_ready;
  logic           src_ren;
  logic [W-1:0]   src_rdata;
  logic [N-1:0]   inst_full;
  logic [N-1:0]   inst_wen;
  logic [W*J-1:0] job;

  modport master (
    input  src_ready, src_rdata, inst_full,
    output src_ren, inst_wen, job
  );

  modport slave (
    output src_ready, src_rdata, inst_full,
    input  src_ren, inst_wen, job
  );
endinterface

// File: rtl/csa_job_scheduler.sv
// Fetches fixed-length job records from a source FIFO and dispatches each one
// to a calc instance chosen round-robin among the eligible instances.
module csa_job_scheduler #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int CSA_CALC_INST_NUM = 4,
  parameter int JOB_WORDS         = 5,
  parameter int INDEX_WIDTH       = 2
) (
  input  logic                         axi_mm_clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [CSA_CALC_INST_NUM-1:0] inst_mask,
  csa_job_scheduler_if.master          bus,
  output logic                         busy,
  output logic                         no_inst,
  output logic [INDEX_WIDTH-1:0]       last_inst,
  output logic [31:0]                  job_count
);
  localparam int CNT_W = (JOB_WORDS > 1) ? $clog2(JOB_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, SELECT, GRANT} state_t;

  state_t                        state_reg;
  logic [CNT_W-1:0]              fetch_cnt_reg;
  logic [AXI_DATA_WIDTH-1:0]     job_reg [JOB_WORDS];
  logic [INDEX_WIDTH-1:0]        rr_ptr_reg;
  logic [INDEX_WIDTH-1:0]        sel_reg;
  logic [INDEX_WIDTH-1:0]        last_inst_reg;
  logic                          src_ren_reg;
  logic                          busy_reg;
  logic                          no_inst_reg;
  logic [CSA_CALC_INST_NUM-1:0]  inst_wen_reg;
  logic [31:0]                   job_count_reg;

  logic [CSA_CALC_INST_NUM-1:0]  eligible;
  logic                          found;
  logic [INDEX_WIDTH-1:0]        pick;
  logic [INDEX_WIDTH-1:0]        cand;

  assign eligible = inst_mask & ~bus.inst_full;

  // Search starts one past the last grant so every eligible instance gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= CSA_CALC_INST_NUM; k++) begin
      cand = INDEX_WIDTH'((int'(rr_ptr_reg) + k) % CSA_CALC_INST_NUM);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge axi_mm_clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      fetch_cnt_reg <= '0;
      rr_ptr_reg    <= INDEX_WIDTH'(CSA_CALC_INST_NUM - 1);
      sel_reg       <= '0;
      last_inst_reg <= INDEX_WIDTH'(CSA_CALC_INST_NUM - 1);
      src_ren_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      no_inst_reg   <= 1'b0;
      inst_wen_reg  <= '0;
      job_count_reg <= '0;
      for (int i = 0; i < JOB_WORDS; i++) job_reg[i] <= '0;
    end else begin
      inst_wen_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (enable && bus.src_ready) begin
            state_reg     <= FETCH;
            src_ren_reg   <= 1'b1;
            fetch_cnt_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        FETCH: begin
          // Data lags its strobe by one cycle, so slot k lands on strobe k+1.
          if (fetch_cnt_reg != '0) job_reg[fetch_cnt_reg - 1'b1] <= bus.src_rdata;
          if (fetch_cnt_reg == CNT_W'(JOB_WORDS - 1)) begin
            src_ren_reg <= 1'b0;
            state_reg   <= CAPT;
          end
          fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
        end
        CAPT: begin
          job_reg[JOB_WORDS-1] <= bus.src_rdata;
          state_reg            <= SELECT;
        end
        SELECT: begin
          if (found) begin
            sel_reg      <= pick;
            inst_wen_reg <= CSA_CALC_INST_NUM'(1) << pick;
            no_inst_reg  <= 1'b0;
            state_reg    <= GRANT;
          end else begin
            no_inst_reg  <= 1'b1;
          end
        end
        GRANT: begin
          rr_ptr_reg    <= sel_reg;
          last_inst_reg <= sel_reg;
          job_count_reg <= job_count_reg + 32'd1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < JOB_WORDS; gi++) begin : g_job
    assign bus.job[AXI_DATA_WIDTH*gi +: AXI_DATA_WIDTH] = job_reg[gi];
  end

  assign bus.src_ren  = src_ren_reg;
  assign bus.inst_wen = inst_wen_reg;
  assign busy         = busy_reg;
  assign no_inst      = no_inst_reg;
  assign last_inst    = last_inst_reg;
  assign job_count    = job_count_reg;
endmodule

// File: tb/tb_csa_job_scheduler.sv
// Directed bench for csa_job_scheduler: reset values, fetch/dispatch, round-robin,
// full/mask blocking, mid-fetch reset and job counter wrap.
module tb_csa_job_scheduler;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int J  = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  inst_mask;
  logic          busy;
  logic          no_inst;
  logic [IW-1:0] last_inst;
  logic [31:0]   job_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_job_scheduler_if #(.W(W), .N(N), .J(J)) bus ();

  csa_job_scheduler #(
    .AXI_DATA_WIDTH(W), .CSA_CALC_INST_NUM(N), .JOB_WORDS(J), .INDEX_WIDTH(IW)
  ) dut (
    .axi_mm_clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .inst_mask(inst_mask),
    .bus(bus),
    .busy(busy),
    .no_inst(no_inst),
    .last_inst(last_inst),
    .job_count(job_count)
  );

  // Source FIFO model: data appears the cycle after a read strobe.
  logic [W-1:0] src_mem [64];
  int           rd_ptr = 0;
  logic         fifo_clr = 1'b0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= 0;
    end else if (bus.src_ren) begin
      bus.src_rdata <= src_mem[rd_ptr];
      rd_ptr        <= (rd_ptr + 1) % 64;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load_mem(input logic [W-1:0] base, input logic [W-1:0] step);
    for (int i = 0; i < 64; i++) src_mem[i] = base + W'(i) * step;
  endtask

  task automatic do_reset;
    rst_n         = 1'b0;
    enable        = 1'b0;
    bus.src_ready = 1'b0;
    bus.inst_full = '0;
    inst_mask     = 4'hF;
    fifo_clr      = 1'b1;
    repeat (2) tick;
    fifo_clr      = 1'b0;
    rst_n         = 1'b1;
  endtask

  // Waits for IDLE, requests one job, then drops enable/src_ready once it is running.
  task automatic start_job;
    bit ok = 1'b0;
    for (int t = 0; t < 20 && busy !== 1'b0; t++) tick;
    enable        = 1'b1;
    bus.src_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick;
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    enable        = 1'b0;
    bus.src_ready = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_job busy=%b required 1 within 5 cycles", busy);
    end
  endtask

  task automatic wait_wen(input int budget, output logic [N-1:0] wen, output int cyc);
    wen = '0;
    cyc = -1;
    for (int t = 0; t < budget; t++) begin
      if (bus.inst_wen !== '0) begin
        wen = bus.inst_wen;
        cyc = t;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bus.src_ren !== 1'b0) begin errors++; $display("FAIL rst_src_ren got %b exp 0", bus.src_ren); end
    checks++; if (bus.inst_wen !== 4'b0) begin errors++; $display("FAIL rst_inst_wen got %b exp 0000", bus.inst_wen); end
    checks++; if (bus.job !== '0) begin errors++; $display("FAIL rst_job got %h exp 0", bus.job); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (no_inst !== 1'b0) begin errors++; $display("FAIL rst_no_inst got %b exp 0", no_inst); end
    checks++; if (last_inst !== 2'd3) begin errors++; $display("FAIL rst_last_inst got %0d exp 3", last_inst); end
    checks++; if (job_count !== 32'd0) begin errors++; $display("FAIL rst_job_count got %0d exp 0", job_count); end
  endtask

  task automatic test_single;
    logic [W*J-1:0] exp_job;
    logic [N-1:0]   wen;
    int             ren_cnt;
    exp_job = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    do_reset;
    load_mem(32'h11, 32'h11);
    start_job;
    ren_cnt = (bus.src_ren === 1'b1) ? 1 : 0;
    wen = '0;
    for (int t = 0; t < 20; t++) begin
      tick;
      if (bus.src_ren === 1'b1) ren_cnt++;
      if (bus.inst_wen !== '0) begin
        wen = bus.inst_wen;
        break;
      end
    end
    checks++; if (ren_cnt != J) begin errors++; $display("FAIL single_ren_cycles got %0d exp %0d", ren_cnt, J); end
    checks++; if (wen !== 4'b0001) begin errors++; $display("FAIL single_wen got %b exp 0001", wen); end
    checks++; if (bus.job !== exp_job) begin errors++; $display("FAIL single_job got %h exp %h", bus.job, exp_job); end
    tick;
    checks++; if (bus.inst_wen !== 4'b0) begin errors++; $display("FAIL single_wen_width got %b exp 0000", bus.inst_wen); end
    checks++; if (job_count !== 32'd1) begin errors++; $display("FAIL single_job_count got %0d exp 1", job_count); end
    checks++; if (last_inst !== 2'd0) begin errors++; $display("FAIL single_last_inst got %0d exp 0", last_inst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0]   wen_seq [4];
    int             at [4];
    int             n = 0;
    logic [W*J-1:0] exp_job;
    for (int k = 0; k < J; k++) exp_job[W*k +: W] = 32'h10F + W'(k);
    do_reset;
    load_mem(32'h100, 32'h1);
    enable        = 1'b1;
    bus.src_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick;
      if (bus.inst_wen !== '0) begin
        wen_seq[n] = bus.inst_wen;
        at[n]      = t;
        n++;
        if (n == 4) begin
          enable        = 1'b0;
          bus.src_ready = 1'b0;
          break;
        end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_pulses got %0d exp 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wen_seq[i] !== (4'b0001 << i)) begin
        errors++; $display("FAIL b2b_wen%0d got %b exp %b", i, wen_seq[i], 4'b0001 << i);
      end
      if (i > 0) begin
        checks++;
        if (at[i] - at[i-1] != J + 4) begin
          errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, at[i] - at[i-1], J + 4);
        end
      end
    end
    checks++; if (bus.job !== exp_job) begin errors++; $display("FAIL b2b_job4 got %h exp %h", bus.job, exp_job); end
    tick;
    checks++; if (last_inst !== 2'd3) begin errors++; $display("FAIL b2b_last_inst got %0d exp 3", last_inst); end
    checks++; if (job_count !== 32'd4) begin errors++; $display("FAIL b2b_job_count got %0d exp 4", job_count); end
  endtask

  task automatic test_full;
    logic [N-1:0] wen;
    int           cyc;
    int           bad_ni = 0, bad_w = 0, bad_r = 0;
    bit           seen = 1'b0;
    do_reset;
    load_mem(32'h200, 32'h1);
    start_job;
    wait_wen(20, wen, cyc);
    checks++; if (wen !== 4'b0001) begin errors++; $display("FAIL full_first got %b exp 0001", wen); end
    bus.inst_full = 4'b0010;
    start_job;
    wait_wen(20, wen, cyc);
    checks++; if (wen !== 4'b0100) begin errors++; $display("FAIL full_skip1 got %b exp 0100", wen); end
    // Full rising during the grant cycle must not lose this write.
    bus.inst_full = 4'b1111;
    tick;
    checks++; if (job_count !== 32'd2) begin errors++; $display("FAIL full_grant_kept got %0d exp 2", job_count); end
    start_job;
    for (int t = 0; t < 15; t++) begin
      if (no_inst === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    checks++; if (!seen) begin errors++; $display("FAIL full_no_inst_rise got %b exp 1", no_inst); end
    for (int t = 0; t < 20; t++) begin
      tick;
      if (no_inst !== 1'b1) bad_ni++;
      if (bus.inst_wen !== '0) bad_w++;
      if (bus.src_ren !== 1'b0) bad_r++;
    end
    checks++; if (bad_ni != 0) begin errors++; $display("FAIL full_no_inst_hold got %0d bad cycles exp 0", bad_ni); end
    checks++; if (bad_w != 0) begin errors++; $display("FAIL full_no_wen got %0d bad cycles exp 0", bad_w); end
    checks++; if (bad_r != 0) begin errors++; $display("FAIL full_no_ren got %0d bad cycles exp 0", bad_r); end
    bus.inst_full = 4'b0111;
    wait_wen(5, wen, cyc);
    checks++; if (wen !== 4'b1000) begin errors++; $display("FAIL full_release3 got %b exp 1000", wen); end
    tick;
    checks++; if (no_inst !== 1'b0) begin errors++; $display("FAIL full_no_inst_clear got %b exp 0", no_inst); end
    checks++; if (last_inst !== 2'd3) begin errors++; $display("FAIL full_last_inst got %0d exp 3", last_inst); end
    bus.inst_full = '0;
  endtask

  task automatic test_mask;
    logic [N-1:0] wen;
    logic [N-1:0] exp_seq [3];
    int           cyc;
    int           bad = 0;
    bit           seen = 1'b0;
    exp_seq = '{4'b0001, 4'b0100, 4'b0001};
    do_reset;
    load_mem(32'h300, 32'h1);
    inst_mask = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      start_job;
      wait_wen(20, wen, cyc);
      checks++;
      if (wen !== exp_seq[i]) begin errors++; $display("FAIL mask_alt%0d got %b exp %b", i, wen, exp_seq[i]); end
    end
    inst_mask = 4'b0000;
    start_job;
    for (int t = 0; t < 15; t++) begin
      if (no_inst === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mask_zero_no_inst got %b exp 1", no_inst); end
    for (int t = 0; t < 10; t++) begin
      tick;
      if (no_inst !== 1'b1 || busy !== 1'b1 || bus.src_ren !== 1'b0 || bus.inst_wen !== '0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mask_zero_hold got %0d bad cycles exp 0", bad); end
    inst_mask = 4'hF;
    wait_wen(5, wen, cyc);
    checks++; if (wen !== 4'b0010) begin errors++; $display("FAIL mask_reopen got %b exp 0010", wen); end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0]   wen;
    int             cyc;
    logic [W*J-1:0] exp_job;
    exp_job = {32'hF5, 32'hE4, 32'hD3, 32'hC2, 32'hB1};
    do_reset;
    load_mem(32'hA0, 32'h1);
    start_job;
    wait_wen(20, wen, cyc);
    start_job;
    tick;
    tick;
    checks++; if (bus.src_ren !== 1'b1) begin errors++; $display("FAIL mid_in_fetch got %b exp 1", bus.src_ren); end
    rst_n = 1'b0;
    tick;
    checks++; if (bus.src_ren !== 1'b0) begin errors++; $display("FAIL mid_src_ren got %b exp 0", bus.src_ren); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    checks++; if (job_count !== 32'd0) begin errors++; $display("FAIL mid_job_count got %0d exp 0", job_count); end
    checks++; if (last_inst !== 2'd3) begin errors++; $display("FAIL mid_last_inst got %0d exp 3", last_inst); end
    rst_n    = 1'b1;
    fifo_clr = 1'b1;
    load_mem(32'hB1, 32'h11);
    tick;
    fifo_clr = 1'b0;
    start_job;
    wait_wen(20, wen, cyc);
    checks++; if (wen !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", wen); end
    checks++; if (bus.job !== exp_job) begin errors++; $display("FAIL mid_job got %h exp %h", bus.job, exp_job); end
  endtask

  task automatic test_wrap;
    logic [N-1:0] wen;
    int           cyc;
    do_reset;
    load_mem(32'h400, 32'h1);
    force dut.job_count_reg = 32'hFFFF_FFFF;
    tick;
    release dut.job_count_reg;
    tick;
    checks++; if (job_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp ffffffff", job_count); end
    start_job;
    wait_wen(20, wen, cyc);
    tick;
    checks++; if (job_count !== 32'd0) begin errors++; $display("FAIL wrap_count got %h exp 00000000", job_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full;
    test_mask;
    test_reset_mid;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
